// File: rtl/aes_shift_rows_unit.sv
//------------------------------------------------------------------------------
// aes_shift_rows_unit
//
// Applies the Rijndael ShiftRows / InvShiftRows byte permutation (or a plain
// bypass) to a state of NB columns and queues the result in a small FIFO.
// The permutation itself is pure wiring; the FIFO gives a one-cycle latency
// and decouples the upstream and downstream handshakes.
//
// State layout: byte k lives at bits [W-1-8k -: 8], row = k mod 4,
// column = k div 4. Row offsets are {0,1,2,3} for NB = 4 or 6 and {0,1,3,4}
// for NB = 8.
//
// Parameters:
//   NB        state columns: 4, 6 or 8 (128/192/256-bit block)
//   DEPTH     output buffer entries, 1 to 4
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input transaction present
//   in_ready   out  input accepted this cycle (count < DEPTH, low in reset)
//   in_mode    in   00 ShiftRows, 01 InvShiftRows, 10 bypass, 11 reserved
//   in_data    in   state to transform
//   out_valid  out  buffered result present
//   out_ready  in   downstream accepts the head entry this cycle
//   out_data   out  transformed state at the FIFO head
//   out_err    out  head entry came from reserved mode 11
//   count      out  current buffer occupancy
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module aes_shift_rows_unit #(
   parameter  int NB    = 4,
   parameter  int DEPTH = 2,
   localparam int W     = 32 * NB,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_err,
   output logic [CNT_W-1:0] count
);

   //---------------------------------------------------------------------------
   // Parameter legality
   //---------------------------------------------------------------------------
   if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $fatal(1, "aes_shift_rows_unit: NB must be 4, 6 or 8");
   end

   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $fatal(1, "aes_shift_rows_unit: DEPTH must be in 1..4");
   end

   localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      MODE_SHIFT  = 2'b00,
      MODE_INV    = 2'b01,
      MODE_BYPASS = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   //---------------------------------------------------------------------------
   // Byte permutation: every output byte is a fixed wire from one input byte,
   // so both directions are built statically and selected by mode.
   //---------------------------------------------------------------------------
   logic [W-1:0] fwd_data;
   logic [W-1:0] inv_data;

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         // The two upper rows move one further for the 256-bit block.
         localparam int SH    = (NB == 8 && r >= 2) ? r + 1 : r;
         localparam int DST   = 4 * c + r;
         localparam int SRC_F = 4 * ((c + SH) % NB) + r;
         localparam int SRC_I = 4 * ((c + NB - SH) % NB) + r;

         assign fwd_data[W-1-8*DST -: 8] = in_data[W-1-8*SRC_F -: 8];
         assign inv_data[W-1-8*DST -: 8] = in_data[W-1-8*SRC_I -: 8];
      end
   end

   logic [W-1:0] xform_data;
   logic         xform_err;

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned; a missing default turns this block into a latch.
   always_comb begin
      xform_data = in_data;
      xform_err  = 1'b0;
      case (mode_e'(in_mode))
         MODE_SHIFT:  xform_data = fwd_data;
         MODE_INV:    xform_data = inv_data;
         MODE_BYPASS: xform_data = in_data;
         MODE_RSVD:   xform_err  = 1'b1;
         default:     xform_err  = 1'b0;
      endcase
   end

   //---------------------------------------------------------------------------
   // Output FIFO
   //---------------------------------------------------------------------------
   logic [W-1:0]     data_q [DEPTH];
   logic             err_q  [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             push;
   logic             pop;

   // Ready depends only on stored occupancy (and reset), never on out_ready,
   // so a full buffer cannot accept even when it is being drained.
   assign in_ready  = ~rst & (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign out_data  = data_q[rd_ptr_q];
   assign out_err   = err_q[rd_ptr_q];
   assign count     = count_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         // NOTE: the storage array is cleared on reset because its head entry
         // drives out_data/out_err directly and those must read as zero.
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= xform_data;
            err_q[wr_ptr_q]  <= xform_err;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_unit.sv
//------------------------------------------------------------------------------
// tb_aes_shift_rows_unit
//
// Three instances (NB = 4, 6, 8; DEPTH = 2) share one handshake and the top
// bytes of one 256-bit input bus, so byte k is the same for all of them and
// their FIFOs move in lockstep. Expected results are queued when a transfer
// happens and compared against every instance by a separate output monitor.
// Outputs are left-aligned on a 256-bit view for uniform comparison.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_shift_rows_unit;

   localparam int DEPTH = 2;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic [1:0]   in_mode   = 2'b00;
   logic [255:0] in_data   = '0;
   logic         out_ready = 1'b0;

   logic         force_ready = 1'b0;
   logic         rand_bp     = 1'b0;

   logic         in_ready_a  [3];
   logic         out_valid_a [3];
   logic         out_err_a   [3];
   logic [255:0] out_data_a  [3];
   logic [1:0]   count_a     [3];

   int           total = 0;
   int           bad   = 0;
   int           nb_of [3] = '{4, 6, 8};

   typedef logic [2:0][263:0] exp_t;   // per instance: {7'b0, err, data}
   exp_t exp_q [$];

   always #5 clk = ~clk;

   // out_ready changes 2 time units after the rising edge
   always @(posedge clk) begin
      #2;
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : force_ready;
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int NBG = (g == 0) ? 4 : (g == 1) ? 6 : 8;
      localparam int WG  = 32 * NBG;
      logic [WG-1:0] od;

      aes_shift_rows_unit #(.NB(NBG), .DEPTH(DEPTH)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready_a[g]),
         .in_mode   (in_mode),
         .in_data   (in_data[255 -: WG]),
         .out_valid (out_valid_a[g]),
         .out_ready (out_ready),
         .out_data  (od),
         .out_err   (out_err_a[g]),
         .count     (count_a[g])
      );

      assign out_data_a[g] = 256'(od) << (256 - WG);
   end

   //---------------------------------------------------------------------------
   // Helpers
   //---------------------------------------------------------------------------
   task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Rows as byte lists; ShiftRows rotates row r left by its offset,
   // InvShiftRows rotates it right. Result is left-aligned in 256 bits.
   function automatic logic [255:0] ref_model(input int nb, input logic [1:0] mode,
                                              input logic [255:0] din);
      logic [255:0]  res = '0;
      byte unsigned  row [$];
      int            sh;
      for (int r = 0; r < 4; r++) begin
         row = {};
         for (int c = 0; c < nb; c++) row.push_back(din[255 - 8*(4*c + r) -: 8]);
         sh = (nb == 8 && r >= 2) ? r + 1 : r;
         if (mode == 2'b00)      repeat (sh) row.push_back(row.pop_front());
         else if (mode == 2'b01) repeat (sh) row.push_front(row.pop_back());
         for (int c = 0; c < nb; c++) res[255 - 8*(4*c + r) -: 8] = row[c];
      end
      return res;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
      return v;
   endfunction

   task automatic push_expected(input logic [1:0] m, input logic [255:0] d);
      exp_t e;
      for (int i = 0; i < 3; i++) e[i] = {7'b0, (m == 2'b11), ref_model(nb_of[i], m, d)};
      exp_q.push_back(e);
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] m, input logic [255:0] d);
      logic acc;
      in_valid = 1'b1;
      in_mode  = m;
      in_data  = d;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = in_ready_a[0];
         @(posedge clk);
         if (acc) begin
            push_expected(m, d);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      check("send_timeout", 264'd0, 264'd1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_head(input string name, input int idx,
                             input logic [255:0] exp_d, input logic exp_e);
      @(negedge clk);
      check({name, "_valid"}, 264'(out_valid_a[idx]), 264'd1);
      check({name, "_data"},  264'(out_data_a[idx]),  264'(exp_d));
      check({name, "_err"},   264'(out_err_a[idx]),   264'(exp_e));
      to_drive();
   endtask

   //---------------------------------------------------------------------------
   // Output monitor
   //---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("count_nb%0d", nb_of[i]), 264'(count_a[i]), 264'(exp_q.size()));
            check($sformatf("in_ready_nb%0d", nb_of[i]), 264'(in_ready_a[i]),
                  264'(exp_q.size() < DEPTH));
            check($sformatf("out_valid_nb%0d", nb_of[i]), 264'(out_valid_a[i]),
                  264'(exp_q.size() != 0));
            if (out_valid_a[i] && exp_q.size() != 0)
               check($sformatf("head_nb%0d", nb_of[i]),
                     {7'b0, out_err_a[i], out_data_a[i]}, exp_q[0][i]);
         end
         if (out_valid_a[0] && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      logic [255:0] inc, x, y, a, b, c;
      for (int k = 0; k < 32; k++) inc[255 - 8*k -: 8] = 8'(k);

      // Reset
      @(negedge clk);
      check("rst_in_ready", 264'(in_ready_a[0]), 264'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_out_data", 264'(out_data_a[i]), 264'd0);
         check("rst_out_err",  264'(out_err_a[i]),  264'd0);
         check("rst_ready",    264'(in_ready_a[i]), 264'd1);
      end
      to_drive();

      // Directed permutation vectors
      force_ready = 1'b1;
      send(2'b00, inc);
      @(negedge clk);
      check("sr_fwd_valid", 264'(out_valid_a[0]), 264'd1);
      check("sr_fwd_data",  264'(out_data_a[0]),
            264'({128'h00050a0f04090e03080d02070c01060b, 128'h0}));
      check("sr_fwd_err",   264'(out_err_a[0]), 264'd0);
      check("nb8_row3_off4", 264'(out_data_a[2][231:224]), 264'h13);
      check("nb8_row2_off3", 264'(out_data_a[2][239:232]), 264'h0e);
      check("nb6_row3_off3", 264'(out_data_a[1][231:224]), 264'h0f);
      to_drive();

      send(2'b01, inc);
      check_head("sr_inv", 0, {128'h000d0a0704010e0b0805020f0c090603, 128'h0}, 1'b0);
      send(2'b01, {128'h00050a0f04090e03080d02070c01060b, 128'h0});
      check_head("sr_round", 0, {inc[255:128], 128'h0}, 1'b0);

      // NB=8 round trip: feed its ShiftRows result back through InvShiftRows
      x = rand256();
      send(2'b00, x);
      @(negedge clk);
      y = out_data_a[2];
      to_drive();
      send(2'b01, y);
      check_head("nb8_round", 2, x, 1'b0);

      // Reserved mode then a normal entry
      x = rand256();
      send(2'b11, x);
      check_head("rsvd", 0, {x[255:128], 128'h0}, 1'b1);
      send(2'b00, x);
      check_head("after_rsvd", 0, ref_model(4, 2'b00, x), 1'b0);

      // Backpressure: two accepted, third held until a slot frees
      force_ready = 1'b0;
      a = rand256();
      b = rand256();
      c = rand256();
      send(2'b00, a);
      send(2'b01, b);
      in_valid = 1'b1;
      in_mode  = 2'b10;
      in_data  = c;
      @(negedge clk);
      check("full_count", 264'(count_a[0]), 264'd2);
      check("full_ready", 264'(in_ready_a[0]), 264'd0);
      @(posedge clk);
      #1;
      force_ready = 1'b1;
      @(negedge clk);
      check("full_pop_ready", 264'(in_ready_a[0]), 264'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("pop_no_push_count", 264'(count_a[0]), 264'd1);
      check("pop_no_push_ready", 264'(in_ready_a[0]), 264'd1);
      @(posedge clk);
      push_expected(2'b10, c);
      #1;
      in_valid = 1'b0;
      repeat (4) to_drive();

      // Reset with two entries buffered, pending input and ready downstream
      force_ready = 1'b0;
      send(2'b11, a);
      send(2'b00, b);
      @(negedge clk);
      check("pre_rst_count", 264'(count_a[0]), 264'd2);
      @(posedge clk);
      #1;
      rst         = 1'b1;
      in_valid    = 1'b1;
      in_data     = c;
      force_ready = 1'b1;
      @(negedge clk);
      check("rst_busy_ready", 264'(in_ready_a[0]), 264'd0);
      @(posedge clk);
      exp_q.delete();
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("mid_rst_count", 264'(count_a[i]),     264'd0);
         check("mid_rst_valid", 264'(out_valid_a[i]), 264'd0);
         check("mid_rst_data",  264'(out_data_a[i]),  264'd0);
         check("mid_rst_err",   264'(out_err_a[i]),   264'd0);
      end
      to_drive();

      // Randomized traffic with random backpressure
      rand_bp = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) to_drive();
         send(2'($urandom_range(0, 3)), rand256());
      end
      rand_bp     = 1'b0;
      force_ready = 1'b1;
      repeat (10) to_drive();
      check("drain_empty", 264'(exp_q.size()), 264'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_shift_rows_unit.md
AES_SHIFT_ROWS_UNIT -- requirements
Module: aes_shift_rows_unit

Interface
REQ-001 The unit SHALL have parameter NB, default 4, meaning state columns; legal values are 4, 6 and 8 (Rijndael 128/192/256-bit block); any other value SHALL fail elaboration.
REQ-002 The unit SHALL have parameter DEPTH, default 2, meaning output buffer entries; legal values are 1 to 4.
REQ-003 The unit SHALL have localparam W = 32*NB, the state width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input transaction present.
REQ-007 in_ready  output  1  unit accepts the input transaction this cycle.
REQ-008 in_mode  input  2  transformation select: 00 ShiftRows, 01 InvShiftRows, 10 bypass, 11 reserved.
REQ-009 in_data  input  W  state to transform.
REQ-010 out_valid  output  1  buffered result present.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 out_data  output  W  transformed state.
REQ-013 out_err  output  1  result was produced from reserved mode 11.
REQ-014 count  output  $clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-015 Byte k (0 to 4*NB-1) SHALL occupy bits [W-1-8k -: 8], with row r = k mod 4 and column c = k div 4.
REQ-016 Row shift offsets SHALL be s = {0,1,2,3} for rows 0 to 3 when NB is 4 or 6, and s = {0,1,3,4} when NB is 8.
REQ-017 ShiftRows SHALL produce out[r][c] = in[r][(c+s_r) mod NB].
REQ-018 InvShiftRows SHALL produce out[r][c] = in[r][(c-s_r) mod NB].
REQ-019 Bypass SHALL produce out = in.
REQ-020 Mode 11 SHALL produce the bypass result, with out_err set for that entry only.
REQ-021 A transfer SHALL occur on any rising edge with in_valid and in_ready both high; the transformed state and its err flag are then written into the FIFO buffer.
REQ-022 Latency SHALL be exactly 1 cycle: an accepted transaction appears at the head no earlier than the next cycle.
REQ-023 An empty buffer SHALL present that transaction on out_valid in the cycle after acceptance.
REQ-024 in_ready SHALL equal (count < DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-025 A pop SHALL occur on any rising edge with out_valid and out_ready both high.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-027 When full, a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-028 When count = DEPTH, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-029 When count = 0, out_valid SHALL be 0, while out_data and out_err are don't-care.
REQ-030 out_valid SHALL be (count != 0).
REQ-031 out_data and out_err SHALL come from the FIFO head register, with no combinational path from in_data.
REQ-032 out_valid, out_data and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH.
REQ-034 count SHALL never exceed DEPTH or go below 0.
REQ-035 in_mode SHALL be sampled only on transfer; a mode change during backpressure SHALL NOT affect entries already buffered.

Reset
REQ-036 On rst=1 at a rising edge, count, the pointers and out_valid SHALL become 0, and in_ready SHALL become 1 from the following cycle.
REQ-037 out_data and out_err SHALL reset to 0.
REQ-038 Reset SHALL dominate a simultaneous push or pop.
REQ-039 Buffered entries SHALL be discarded when reset is asserted mid-operation.
REQ-040 While rst=1, in_ready SHALL be 0 and no transfer occurs.

Verification
REQ-041 NB=4, mode 00, in_data 000102030405060708090a0b0c0d0e0f, out_ready=1 -> next cycle out_valid=1, out_data 00050a0f04090e03080d02070c01060b, out_err=0.
REQ-042 NB=4, mode 01, same input -> out_data 000d0a0704010e0b0805020f0c090603; feeding the mode 00 result back in with mode 01 -> returns the original input.
REQ-043 NB=8, mode 00 then 01 on random data -> the round trip is the identity; spot-check row 3 uses offset 4 and row 2 uses offset 3; NB=6 row 3 uses offset 3.
REQ-044 DEPTH=2, out_ready=0, three back-to-back valid inputs -> first two accepted, count=2, in_ready=0, third held; raise out_ready -> outputs emerge in order, and the third is accepted only after count drops below 2.
REQ-045 Full buffer, simultaneous in_valid and out_ready -> pop occurs, no push that cycle, count=1.
REQ-046 Mode 11 input -> out_data equals in_data with out_err=1; the next mode 00 entry has out_err=0; rst asserted with count=2 -> next cycle count=0, out_valid=0, out_data=0.
